// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS-subset control sequencer: FETCH/DECODE/EXECUTE/MEM/WB over one handshaked memory port.
// Optional retired-instruction counter (InstrCount port) enabled by defining MC_PERF_COUNT_EN.
module mc_ctrl_fsm #(
  parameter int OPW  = 6,
  parameter int AOPW = 4,
  parameter int CNTW = 32
) (
  input  logic            CLK,
  input  logic            Reset_L,
  input  logic [OPW-1:0]  Opcode,
  input  logic            Zero,
  input  logic            MemAck,
  output logic            MemReq,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IorD,
  output logic            IRWrite,
  output logic            PCWrite,
  output logic [1:0]      PCSrc,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [AOPW-1:0] ALUop,
  output logic            RegDst,
  output logic            MemToReg,
  output logic            RegWrite,
`ifdef MC_PERF_COUNT_EN
  output logic [CNTW-1:0] InstrCount,
`endif
  output logic            Illegal
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_EXEC_I  = 4'd3,
    S_WB_R    = 4'd4,
    S_WB_I    = 4'd5,
    S_MEMADDR = 4'd6,
    S_MEMRD   = 4'd7,
    S_WB_MEM  = 4'd8,
    S_MEMWR   = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_TRAP    = 4'd12
  } state_t;

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPW-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPW-1:0] OP_SLTI  = 6'b001010;

  localparam logic [AOPW-1:0] ALU_ADD  = 4'b0010;
  localparam logic [AOPW-1:0] ALU_SUB  = 4'b0110;
  localparam logic [AOPW-1:0] ALU_AND  = 4'b0000;
  localparam logic [AOPW-1:0] ALU_OR   = 4'b0001;
  localparam logic [AOPW-1:0] ALU_SLT  = 4'b0111;
  localparam logic [AOPW-1:0] ALU_RTYP = 4'b1111;

  state_t state, next_state;
  logic   illegal_q;

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == S_TRAP) illegal_q <= 1'b1;
    end
  end

  assign Illegal = illegal_q;

  // Decode is gated by Reset_L so every strobe is low while reset is held,
  // even though the reset state (FETCH) would otherwise request memory.
  always_comb begin
    next_state = state;
    MemReq     = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUop      = ALU_ADD;
    RegDst     = 1'b0;
    MemToReg   = 1'b0;
    RegWrite   = 1'b0;
    if (Reset_L) begin
      unique case (state)
        S_FETCH: begin
          MemReq  = 1'b1;
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          if (MemAck) begin
            IRWrite    = 1'b1;
            PCWrite    = 1'b1;
            next_state = S_DECODE;
          end
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          unique case (Opcode)
            OP_RTYPE:                          next_state = S_EXEC_R;
            OP_LW, OP_SW:                      next_state = S_MEMADDR;
            OP_BEQ:                            next_state = S_BRANCH;
            OP_J:                              next_state = S_JUMP;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state = S_EXEC_I;
            default:                           next_state = S_TRAP;
          endcase
        end
        S_EXEC_R: begin
          ALUSrcA    = 1'b1;
          ALUop      = ALU_RTYP;
          next_state = S_WB_R;
        end
        S_EXEC_I: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          unique case (Opcode)
            OP_ANDI: ALUop = ALU_AND;
            OP_ORI:  ALUop = ALU_OR;
            OP_SLTI: ALUop = ALU_SLT;
            default: ALUop = ALU_ADD;
          endcase
          next_state = S_WB_I;
        end
        S_WB_R: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          next_state = S_FETCH;
        end
        S_WB_I: begin
          RegWrite   = 1'b1;
          next_state = S_FETCH;
        end
        S_MEMADDR: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          next_state = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          MemReq  = 1'b1;
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (MemAck) next_state = S_WB_MEM;
        end
        S_WB_MEM: begin
          RegWrite   = 1'b1;
          MemToReg   = 1'b1;
          next_state = S_FETCH;
        end
        S_MEMWR: begin
          MemReq   = 1'b1;
          MemWrite = 1'b1;
          IorD     = 1'b1;
          if (MemAck) next_state = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA    = 1'b1;
          ALUop      = ALU_SUB;
          PCSrc      = 2'b01;
          PCWrite    = Zero;
          next_state = S_FETCH;
        end
        S_JUMP: begin
          PCSrc      = 2'b10;
          PCWrite    = 1'b1;
          next_state = S_FETCH;
        end
        S_TRAP:  next_state = S_TRAP;
        default: next_state = S_FETCH;
      endcase
    end
  end

`ifdef MC_PERF_COUNT_EN
  logic retire;

  always_comb begin
    retire = 1'b0;
    if (next_state == S_FETCH) begin
      unique case (state)
        S_WB_R, S_WB_I, S_WB_MEM, S_MEMWR, S_BRANCH, S_JUMP: retire = 1'b1;
        default: retire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L)    InstrCount <= '0;
    else if (retire) InstrCount <= InstrCount + 1'b1;
  end
`endif

endmodule
